// File: rtl/button_debounce_if.sv
// Pushbutton debouncer signal bundle: raw button level in, debounced level, strobes and press count out.
interface button_debounce_if;
    logic       btn_in;
    logic       level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic [7:0] press_count;

    modport master (
        output btn_in,
        input  level, press_pulse, release_pulse, long_pulse, press_count
    );

    modport slave (
        input  btn_in,
        output level, press_pulse, release_pulse, long_pulse, press_count
    );
endinterface

// File: rtl/button_debounce.sv
// Synchronizing pushbutton debouncer with press/release strobes and a wrapping press counter.
// Define BUTTON_DEBOUNCE_LONG_PRESS_EN to build the long-press hold counter and long_pulse strobe.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
    parameter int unsigned LONG_PRESS_CYCLES = 100000000
) (
    input logic              clk,
    input logic              resetn,
    button_debounce_if.slave bus
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    if (DEBOUNCE_CYCLES < 1 || LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_param_check
        $error("button_debounce: need DEBOUNCE_CYCLES >= 1 and LONG_PRESS_CYCLES > DEBOUNCE_CYCLES");
    end

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    logic             s1, s2;
    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             level_q, level_next;
    logic             press_q, press_next;
    logic             release_q, release_next;
    logic [7:0]       count_q, count_next;

    // Two-flop synchronizer; the raw button is asynchronous to clk.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= bus.btn_in;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            level_q   <= level_next;
            press_q   <= press_next;
            release_q <= release_next;
            count_q   <= count_next;
        end
    end

    // Any bounce back to the old level during a wait state abandons the qualification.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        level_next   = level_q;
        press_next   = 1'b0;
        release_next = 1'b0;
        count_next   = count_q;
        case (state)
            IDLE: begin
                if (s2) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!s2) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt < CNT_MAX) begin
                    cnt_next = cnt + 1'b1;
                end else begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                    level_next = 1'b1;
                    press_next = 1'b1;
                    count_next = count_q + 8'd1;
                end
            end
            PRESSED: begin
                if (!s2) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (s2) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else if (cnt < CNT_MAX) begin
                    cnt_next = cnt + 1'b1;
                end else begin
                    state_next   = IDLE;
                    cnt_next     = '0;
                    level_next   = 1'b0;
                    release_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign bus.level         = level_q;
    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign bus.press_count   = count_q;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);

    logic [HOLD_W-1:0] hold_cnt, hold_next;
    logic              long_q, long_next;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_cnt <= '0;
            long_q   <= 1'b0;
        end else begin
            hold_cnt <= hold_next;
            long_q   <= long_next;
        end
    end

    // Saturation makes the strobe fire once per press; a release accepted on the same edge wins.
    always_comb begin
        hold_next = hold_cnt;
        long_next = 1'b0;
        if (state == PRESS_WAIT && state_next == PRESSED) begin
            hold_next = '0;
        end else if ((state == PRESSED || state == RELEASE_WAIT) && hold_cnt < HOLD_MAX) begin
            hold_next = hold_cnt + 1'b1;
            long_next = (hold_cnt + 1'b1 == HOLD_MAX) && (state_next != IDLE);
        end
    end

    assign bus.long_pulse = long_q;
`else
    assign bus.long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20.
module tb_button_debounce;
    localparam int DEB  = 4;
    localparam int LONG = 20;

    logic clk = 1'b0;
    logic resetn;

    button_debounce_if bus ();

    button_debounce #(
        .DEBOUNCE_CYCLES  (DEB),
        .LONG_PRESS_CYCLES(LONG)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       btn;
        logic       level;
        logic       press;
        logic       rel;
        logic [7:0] count;
    } vec_t;

    vec_t vecs[$];

    int total = 0;
    int bad   = 0;
    int press_seen = 0;
    int long_seen  = 0;
    logic prev_press = 1'b0, prev_rel = 1'b0, prev_long = 1'b0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic b);
        bus.btn_in = b;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic add_vec(input logic b, input logic l, input logic p, input logic r, input logic [7:0] c);
        vec_t v;
        v.btn = b; v.level = l; v.press = p; v.rel = r; v.count = c;
        vecs.push_back(v);
    endtask

    function automatic logic [31:0] outs();
        return {20'd0, bus.level, bus.press_pulse, bus.release_pulse, bus.long_pulse, bus.press_count};
    endfunction

    // Strobe exclusivity and single-cycle width are checked whenever any strobe is up.
    always @(negedge clk) begin
        if (bus.press_pulse) press_seen++;
        if (bus.long_pulse) long_seen++;
        if (bus.press_pulse || bus.release_pulse || bus.long_pulse) begin
            check_output("strobe_onehot",
                         32'(int'(bus.press_pulse) + int'(bus.release_pulse) + int'(bus.long_pulse)), 32'd1);
            check_output("strobe_single_cycle",
                         {29'd0, bus.press_pulse & prev_press, bus.release_pulse & prev_rel,
                          bus.long_pulse & prev_long}, 32'd0);
        end
        prev_press = bus.press_pulse;
        prev_rel   = bus.release_pulse;
        prev_long  = bus.long_pulse;
    end

    initial begin
        int base;
        int press_idx;
        int long_idx;
        int nlong;

        // Short bounce from idle, clean press, short release bounce, clean release.
        repeat (3) add_vec(1, 0, 0, 0, 0);
        repeat (5) add_vec(0, 0, 0, 0, 0);
        repeat (6) add_vec(1, 0, 0, 0, 0);
        add_vec(1, 1, 1, 0, 1);
        add_vec(1, 1, 0, 0, 1);
        repeat (2) add_vec(0, 1, 0, 0, 1);
        repeat (4) add_vec(1, 1, 0, 0, 1);
        repeat (6) add_vec(0, 1, 0, 0, 1);
        add_vec(0, 0, 0, 1, 1);
        add_vec(0, 0, 0, 0, 1);

        bus.btn_in = 1'b0;
        resetn = 1'b1;
        #2 resetn = 1'b0;
        #1 check_output("reset_state", outs(), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].btn);
            check_output($sformatf("vec%0d", i), outs(),
                         {20'd0, vecs[i].level, vecs[i].press, vecs[i].rel, 1'b0, vecs[i].count});
        end

        // 256 clean presses: counter wraps and returns to its starting value.
        #1 base = press_seen;
        for (int i = 0; i < 256; i++) begin
            repeat (10) apply_stimulus(1'b1);
            repeat (10) apply_stimulus(1'b0);
            if (i == 253) check_output("count_255", {24'd0, bus.press_count}, 32'd255);
            if (i == 254) check_output("count_wrap_0", {24'd0, bus.press_count}, 32'd0);
        end
        check_output("count_after_256", {24'd0, bus.press_count}, 32'd1);
        #1 check_output("press_pulses_256", 32'(press_seen - base), 32'd256);

        // Long hold: press accepted on the 7th edge, long strobe 20 cycles later.
        press_idx = -1;
        long_idx  = -1;
        nlong     = 0;
        for (int k = 0; k < 40; k++) begin
            apply_stimulus(1'b1);
            if (bus.press_pulse && press_idx < 0) press_idx = k;
            if (bus.long_pulse) begin
                nlong++;
                long_idx = k;
            end
        end
        check_output("long_hold_press_edge", 32'(press_idx), 32'd6);
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
        check_output("long_pulse_count", 32'(nlong), 32'd1);
        check_output("long_pulse_delay", 32'(long_idx - press_idx), 32'd20);
`else
        check_output("long_pulse_absent", 32'(nlong), 32'd0);
`endif
        repeat (10) apply_stimulus(1'b0);

        // Reset in the middle of a press qualification, button still held.
        repeat (4) apply_stimulus(1'b1);
        resetn = 1'b0;
        #1 check_output("async_reset_mid_debounce", outs(), 32'd0);
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        press_idx = -1;
        for (int k = 0; k < 12; k++) begin
            apply_stimulus(1'b1);
            if (bus.press_pulse && press_idx < 0) press_idx = k;
        end
        check_output("requalify_press_edge", 32'(press_idx), 32'd6);
        check_output("requalify_state", {31'd0, bus.level}, 32'd1);
        check_output("requalify_count", {24'd0, bus.press_count}, 32'd1);

        // Asynchronous clear while the debounced level is high.
        #2 resetn = 1'b0;
        #1 check_output("async_clear_pressed", outs(), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) apply_stimulus(1'b0);

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
        #1 check_output("long_pulses_total", 32'(long_seen), 32'd1);
`else
        #1 check_output("long_pulses_total", 32'(long_seen), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
